// File: rtl/layer_requant_if.sv
// layer_requant_if: accumulator stream in, int8 lane bank out.
// master drives start/shift and the acc/bias beats; slave (the requantiser) drives ready, lanes and status.
interface layer_requant_if #(parameter int N_OUT = 28, parameter int ACC_W = 24);
  logic start;
  logic [4:0] shift;
  logic acc_valid;
  logic acc_ready;
  logic signed [ACC_W-1:0] acc_data;
  logic signed [ACC_W-1:0] bias_data;
  logic [8*N_OUT-1:0] dpl_flat;
  logic rescale;
  logic busy;
  logic sat_flag;
  modport master(output start, shift, acc_valid, acc_data, bias_data,
                 input acc_ready, dpl_flat, rescale, busy, sat_flag);
  modport slave(input start, shift, acc_valid, acc_data, bias_data,
                output acc_ready, dpl_flat, rescale, busy, sat_flag);
endinterface

// File: rtl/layer_requant.sv
// layer_requant: bias add, rounding right shift and int8 saturation of a neuron stream into an N_OUT-lane bank.
// Ports: clk, rst (async, active-high), bus (slave): start/shift begin a frame, acc_valid/acc_ready/acc_data/bias_data
// carry one beat per neuron, dpl_flat holds the int8 lanes, rescale pulses when all lanes are written,
// busy flags a frame in progress, sat_flag is sticky per frame.
module layer_requant #(parameter int N_OUT = 28, parameter int ACC_W = 24) (
  input logic clk,
  input logic rst,
  layer_requant_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
  localparam int CW = $clog2(N_OUT + 1);
  localparam logic signed [ACC_W+1:0] PMAX = 127;
  localparam logic signed [ACC_W+1:0] NMIN = -128;
  state_t state, nxt;
  logic [CW-1:0] in_cnt, out_cnt;
  logic [4:0] sh;
  logic signed [ACC_W:0] s1;
  logic v1;
  logic signed [ACC_W+1:0] rnd, r;
  logic [7:0] q;
  logic sat, go, accept;
  assign go = bus.start && state == IDLE;
  assign accept = bus.acc_valid && bus.acc_ready;
  assign bus.acc_ready = state == COLLECT && in_cnt < CW'(N_OUT);
  assign bus.busy = state != IDLE;
  assign bus.rescale = state == DONE;
  always_comb begin
    rnd = sh == 5'd0 ? '0 : {{(ACC_W+1){1'b0}}, 1'b1} << (sh - 5'd1);
    r = ($signed({s1[ACC_W], s1}) + rnd) >>> sh;
    sat = r > PMAX || r < NMIN;
    q = r > PMAX ? 8'h7f : r < NMIN ? 8'h80 : r[7:0];
  end
  // DONE follows the cycle in which the last lane became visible, so the
  // downstream latch sees a settled bank during the whole rescale cycle.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = bus.start ? COLLECT : IDLE;
      COLLECT: nxt = accept && in_cnt == CW'(N_OUT - 1) ? DRAIN : COLLECT;
      DRAIN: nxt = out_cnt == CW'(N_OUT) ? DONE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      in_cnt <= '0;
      out_cnt <= '0;
      sh <= '0;
      s1 <= '0;
      v1 <= 1'b0;
      bus.dpl_flat <= '0;
      bus.sat_flag <= 1'b0;
    end else begin
      state <= nxt;
      if (go) begin
        in_cnt <= '0;
        out_cnt <= '0;
        sh <= bus.shift;
        bus.sat_flag <= 1'b0;
      end else begin
        if (accept) in_cnt <= in_cnt + 1'b1;
        if (v1 && out_cnt < CW'(N_OUT)) begin
          bus.dpl_flat[8*out_cnt +: 8] <= q;
          out_cnt <= out_cnt + 1'b1;
          if (sat) bus.sat_flag <= 1'b1;
        end
      end
      v1 <= accept;
      s1 <= $signed({bus.acc_data[ACC_W-1], bus.acc_data}) + $signed({bus.bias_data[ACC_W-1], bus.bias_data});
    end
endmodule

// File: tb/tb_layer_requant.sv
// tb_layer_requant: table vectors, random frames and corner sequences against an arithmetic reference model.
module tb_layer_requant;
  localparam int N = 28;
  localparam int W = 24;
  typedef struct {
    logic signed [W-1:0] acc;
    logic signed [W-1:0] bias;
    logic [4:0] sh;
    logic signed [7:0] q;
    bit sat;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  logic signed [W-1:0] f_acc[N];
  logic signed [W-1:0] f_bias[N];
  logic [4:0] f_sh;
  logic [8*N-1:0] exp_flat, prev_flat;
  bit exp_sat;
  layer_requant_if #(.N_OUT(N), .ACC_W(W)) bus();
  layer_requant #(.N_OUT(N), .ACC_W(W)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_flat(input string name, input logic [8*N-1:0] act, input logic [8*N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: floor((s + 2^(sh-1)) / 2^sh) with exact integer division, then clamp.
  function automatic void model(input longint acc, input longint bias, input int sh,
                                output logic [7:0] q, output bit sat);
    longint s, d, n, r;
    s = acc + bias;
    if (sh == 0) r = s;
    else begin
      d = longint'(1) << sh;
      n = s + d / 2;
      r = n / d;
      if (n % d != 0 && n < 0) r--;
    end
    sat = r > 127 || r < -128;
    q = sat ? (r > 0 ? 8'h7f : 8'h80) : r[7:0];
  endfunction

  function automatic void build_exp();
    logic [7:0] q;
    bit s;
    exp_sat = 1'b0;
    for (int i = 0; i < N; i++) begin
      model(f_acc[i], f_bias[i], int'(f_sh), q, s);
      exp_flat[8*i +: 8] = q;
      exp_sat |= s;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frame(input logic [4:0] sh);
    for (int i = 0; i < N; i++) begin
      f_acc[i] = '0;
      f_bias[i] = '0;
    end
    f_sh = sh;
  endtask

  task automatic run_frame(input int gap_pct, input bit poke_start, input bit b2b, input bit chk_lanes);
    int k = 0;
    int first = -1;
    prev_flat = exp_flat;
    build_exp();
    bus.start = 1'b1;
    bus.shift = f_sh;
    step();
    bus.start = 1'b0;
    bus.shift = ~f_sh;
    chk("busy_collect", bus.busy, 1);
    chk("sat_cleared", bus.sat_flag, 0);
    if (b2b) chk_flat("hold_prev", bus.dpl_flat, prev_flat);
    for (int c = 0; c < 2000 && k < N; c++) begin
      bus.acc_valid = $urandom_range(99) >= gap_pct;
      bus.acc_data = f_acc[k];
      bus.bias_data = f_bias[k];
      bus.start = poke_start && k == 10;
      if (bus.acc_valid && bus.acc_ready) k++;
      step();
    end
    chk("beats", k, N);
    chk("ready_after_last", bus.acc_ready, 0);
    bus.acc_valid = 1'b1;
    bus.acc_data = 24'sh7fffff;
    bus.bias_data = 24'sh7fffff;
    bus.start = poke_start;
    for (int c = 1; c <= 8 && first < 0; c++) begin
      step();
      bus.start = 1'b0;
      if (bus.rescale) first = c;
    end
    bus.start = 1'b0;
    chk("rescale_lat", first, 2);
    if (chk_lanes) begin
      chk_flat("lanes", bus.dpl_flat, exp_flat);
      chk("sat_flag", bus.sat_flag, exp_sat);
    end
    step();
    bus.acc_valid = 1'b0;
    chk("rescale_once", bus.rescale, 0);
    chk("busy_drop", bus.busy, 0);
    if (chk_lanes) chk_flat("lanes_hold", bus.dpl_flat, exp_flat);
  endtask

  initial begin
    vec_t tbl[9];
    int k;
    logic [8*N-1:0] snap;
    tbl = '{
      '{24'sd100, 24'sd0, 5'd2, 8'sd25, 1'b0},
      '{24'sd6, 24'sd0, 5'd2, 8'sd2, 1'b0},
      '{-24'sd6, 24'sd0, 5'd2, -8'sd1, 1'b0},
      '{24'sd5, 24'sd0, 5'd2, 8'sd1, 1'b0},
      '{-24'sd7, 24'sd0, 5'd2, -8'sd2, 1'b0},
      '{24'sd1000, 24'sd24, 5'd3, 8'sd127, 1'b1},
      '{-24'sd100000, 24'sd0, 5'd4, -8'sd128, 1'b1},
      '{24'sd100, -24'sd228, 5'd0, -8'sd128, 1'b0},
      '{24'sd255, 24'sd0, 5'd1, 8'sd127, 1'b1}
    };
    bus.start = 1'b0;
    bus.shift = '0;
    bus.acc_valid = 1'b0;
    bus.acc_data = '0;
    bus.bias_data = '0;
    exp_flat = '0;
    repeat (3) step();
    chk_flat("rst_lanes", bus.dpl_flat, '0);
    chk("rst_ready", bus.acc_ready, 0);
    chk("rst_rescale", bus.rescale, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sat", bus.sat_flag, 0);
    rst = 1'b0;
    step();
    // acc_valid in IDLE must not touch the bank
    bus.acc_valid = 1'b1;
    bus.acc_data = 24'sd1000;
    repeat (5) step();
    bus.acc_valid = 1'b0;
    chk_flat("idle_valid", bus.dpl_flat, '0);
    chk("idle_busy", bus.busy, 0);
    // one directed vector per frame in lane 0
    foreach (tbl[j]) begin
      clear_frame(tbl[j].sh);
      f_acc[0] = tbl[j].acc;
      f_bias[0] = tbl[j].bias;
      run_frame(0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("tbl%0d_q", j), $signed(bus.dpl_flat[7:0]), tbl[j].q);
      chk($sformatf("tbl%0d_sat", j), bus.sat_flag, tbl[j].sat);
    end
    // bubbles: lane i = i*4 with shift 2 gives i
    clear_frame(5'd2);
    for (int i = 0; i < N; i++) f_acc[i] = W'(i * 4);
    run_frame(50, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) chk($sformatf("bubble_lane%0d", i), $signed(bus.dpl_flat[8*i +: 8]), i);
    // stray starts during COLLECT and DRAIN
    clear_frame(5'($urandom_range(12)));
    for (int i = 0; i < N; i++) f_acc[i] = W'($urandom);
    run_frame(20, 1'b1, 1'b0, 1'b1);
    // reset after 10 beats
    bus.start = 1'b1;
    bus.shift = 5'd0;
    step();
    bus.start = 1'b0;
    bus.acc_valid = 1'b1;
    bus.acc_data = 24'sd50;
    k = 0;
    for (int c = 0; c < 100 && k < 10; c++) begin
      if (bus.acc_ready) k++;
      step();
    end
    bus.acc_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk_flat("midrst_lanes", bus.dpl_flat, '0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ready", bus.acc_ready, 0);
    k = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) rst = 1'b0;
      step();
      if (bus.rescale) k++;
    end
    chk("midrst_no_rescale", k, 0);
    exp_flat = '0;
    // random frames, including full shift range and back-to-back
    for (int f = 0; f < 8; f++) begin
      clear_frame(5'($urandom_range(W)));
      for (int i = 0; i < N; i++) begin
        f_acc[i] = $signed(W'($urandom)) >>> $urandom_range(W - 1);
        f_bias[i] = $signed(W'($urandom)) >>> $urandom_range(W - 1, 6);
      end
      run_frame(f % 2 == 0 ? 0 : 40, 1'b0, f > 0, 1'b1);
    end
    clear_frame(5'd0);
    for (int i = 0; i < N; i++) f_acc[i] = -24'sd3;
    run_frame(0, 1'b0, 1'b1, 1'b1);
    chk("b2b_lane0", $signed(bus.dpl_flat[7:0]), -3);
    chk("b2b_lane27", $signed(bus.dpl_flat[8*N-1 -: 8]), -3);
    // out-of-range shift: values undefined, FSM must still complete
    snap = bus.dpl_flat;
    clear_frame(5'd31);
    run_frame(0, 1'b0, 1'b0, 1'b0);
    exp_flat = snap;
    clear_frame(5'd1);
    for (int i = 0; i < N; i++) f_acc[i] = W'(2 * i);
    run_frame(10, 1'b0, 1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
